// File: rtl/cfg_chain_programmer_if.sv
// Stream bundle for the configuration chain programmer: config words in,
// readback words out. The DUT sits on the slave side of this bundle.
interface cfg_chain_programmer_if #(
   parameter int WORD_W = 8
) ();
   logic              s_valid;
   logic [WORD_W-1:0] s_data;
   logic              s_ready;
   logic              m_valid;
   logic [WORD_W-1:0] m_data;

   modport master (
      output s_valid, s_data,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data,
      output s_ready, m_valid, m_data
   );
endinterface

// File: rtl/cfg_chain_programmer.sv
// Host-side driver for the fabric configuration shift chain. Serialises
// stream words onto prog_clk/prog_en/prog_in, LSB first, and returns the
// chain's previous contents, captured from prog_out, as readback words.
module cfg_chain_programmer #(
   parameter int CHAIN_LEN = 80,
   parameter int WORD_W    = 8,
   parameter int CLK_DIV   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   cfg_chain_programmer_if.slave  bus,
   output logic                   busy,
   output logic                   done,
   output logic                   prog_clk,
   output logic                   prog_en,
   output logic                   prog_in,
   input  logic                   prog_out
);

   localparam int CBW = $clog2(CHAIN_LEN + 1);
   localparam int WBW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int DBW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CBW-1:0] LAST_BIT  = CBW'(CHAIN_LEN - 1);
   localparam logic [WBW-1:0] WBIT_LAST = WBW'(WORD_W - 1);
   localparam logic [DBW-1:0] DIV_LAST  = DBW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [DBW-1:0]     div_q, div_d;        // cycles spent in current phase
   logic [CBW-1:0]     bit_q, bit_d;        // bits shifted so far
   logic [WBW-1:0]     wbit_q, wbit_d;      // bit position within current word
   logic [WORD_W-1:0]  tx_q, tx_d;
   logic [WORD_W-1:0]  rx_q, rx_d;
   logic [WORD_W-1:0]  rx_new;

   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               prog_clk_q, prog_clk_d;
   logic               prog_en_q, prog_en_d;
   logic               prog_in_q, prog_in_d;
   logic               s_ready_q, s_ready_d;
   logic               m_valid_q, m_valid_d;
   logic [WORD_W-1:0]  m_data_q, m_data_d;
   logic               handshake;

   // abort withdraws ready in the same cycle so a word offered alongside an
   // abort is never consumed; every other output comes straight from a flop.
   assign bus.s_ready = s_ready_q & ~abort;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign prog_clk    = prog_clk_q;
   assign prog_en     = prog_en_q;
   assign prog_in     = prog_in_q;

   assign handshake = bus.s_valid & s_ready_q & ~abort;

   // Next-state, counters, shift registers and next output values.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      wbit_d    = wbit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      m_valid_d = 1'b0;
      m_data_d  = m_data_q;
      rx_new    = rx_q;
      rx_new[wbit_q] = prog_out;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               div_d   = '0;
               bit_d   = '0;
               wbit_d  = '0;
               tx_d    = '0;
               rx_d    = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (handshake) begin
               tx_d    = bus.s_data;
               div_d   = '0;
               state_d = ST_LOW;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_LOW: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = ST_HIGH;
               // Capture just before the rising edge that would overwrite it.
               if ((wbit_q == WBIT_LAST) || (bit_q == LAST_BIT)) begin
                  m_valid_d = 1'b1;
                  m_data_d  = rx_new;
                  rx_d      = '0;
               end else begin
                  rx_d = rx_new;
               end
            end else begin
               div_d = div_q + DBW'(1);
            end
         end
         ST_HIGH: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               bit_d  = bit_q + CBW'(1);
               tx_d   = tx_q >> 32'd1;
               wbit_d = (wbit_q == WBIT_LAST) ? '0 : (wbit_q + WBW'(1));
               if (bit_q == LAST_BIT) begin
                  state_d = ST_DONE;
               end else if (wbit_q == WBIT_LAST) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_LOW;
               end
            end else begin
               div_d = div_q + DBW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // abort beats every other transition, including start in IDLE, and
      // suppresses any readback word that was about to be emitted.
      if (abort) begin
         state_d   = ST_IDLE;
         m_valid_d = 1'b0;
         m_data_d  = m_data_q;
      end else begin
         state_d = state_d;
      end

      // Outputs are a function of the state being entered, so the flops
      // present them in the same cycle that state becomes current.
      busy_d     = (state_d != ST_IDLE);
      prog_en_d  = (state_d == ST_FETCH) || (state_d == ST_LOW) || (state_d == ST_HIGH);
      prog_clk_d = (state_d == ST_HIGH);
      s_ready_d  = (state_d == ST_FETCH);
      done_d     = (state_d == ST_DONE);
      prog_in_d  = prog_en_d ? tx_d[0] : 1'b0;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters, shift registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         bit_q      <= '0;
         wbit_q     <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         prog_clk_q <= 1'b0;
         prog_en_q  <= 1'b0;
         prog_in_q  <= 1'b0;
         s_ready_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
      end else begin
         div_q      <= div_d;
         bit_q      <= bit_d;
         wbit_q     <= wbit_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         prog_clk_q <= prog_clk_d;
         prog_en_q  <= prog_en_d;
         prog_in_q  <= prog_in_d;
         s_ready_q  <= s_ready_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
      end
   end

endmodule
